waterfall_led_driver: RTL and testbench

Consumer end of the 3-bit up/down waterfall position counter. It samples the counter value and infers the step direction, wrap events and stalls from successive samples. It renders the position onto 8 LEDs in one of four display modes and blinks the display while the counter is idle. It sits between the position counter and the board LED pins, in the clk_1hz domain.

---
 rtl/waterfall_pkg.sv | 24 ++
 rtl/waterfall_led_driver_classify.sv | 34 +++
 rtl/waterfall_led_driver.sv | 106 ++++++++++
 tb/tb_waterfall_led_driver.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/waterfall_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | waterfall_pkg: shared widths, display modes and step classes        |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
package waterfall_pkg;

  localparam int LED_W = 8;
  localparam int POS_W = 3;

  localparam logic [1:0] MODE_DOT   = 2'b00;
  localparam logic [1:0] MODE_TRAIL = 2'b01;
  localparam logic [1:0] MODE_BAR   = 2'b10;
  localparam logic [1:0] MODE_OFF   = 2'b11;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STEP_UP = 2'd1,
    STEP_DN = 2'd2,
    JUMP    = 2'd3
  } step_cls_t;

endpackage
`default_nettype wire

// File: rtl/waterfall_led_driver_classify.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wf_step_classify: classifies the step between two counter samples   |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module wf_step_classify
  import waterfall_pkg::*;
(
  input  logic [POS_W-1:0] cnt_q,
  input  logic [POS_W-1:0] prev_q,
  output step_cls_t        step_cls,
  output logic             wrap_cond
);

  logic [POS_W-1:0] w_diff;

  // Modulo-8 difference falls out of the natural 3-bit wraparound
  assign w_diff = cnt_q - prev_q;

  always_comb begin
    step_cls = JUMP;
    case (w_diff)
      3'd0:    step_cls = HOLD;
      3'd1:    step_cls = STEP_UP;
      3'd7:    step_cls = STEP_DN;
      default: step_cls = JUMP;
    endcase
  end

  assign wrap_cond = ((step_cls == STEP_UP) && (cnt_q == 3'd0)) ||
                     ((step_cls == STEP_DN) && (cnt_q == 3'd7));

endmodule
`default_nettype wire

// File: rtl/waterfall_led_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | waterfall_led_driver: renders the waterfall position onto 8 LEDs    |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module waterfall_led_driver
  import waterfall_pkg::*;
#(
  parameter int IDLE_CYC = 4
) (
  input  logic             clk_1hz,
  input  logic             rst_n,
  input  logic [POS_W-1:0] count,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led,
  output logic             dir,
  output logic             wrap,
  output logic             idle
);

  localparam logic [3:0] C_IDLE_MAX = 4'(IDLE_CYC);

  logic [POS_W-1:0] r_cnt_q;
  logic [POS_W-1:0] r_prev_q;
  logic [3:0]       r_idle_cnt;
  logic             r_phase;

  step_cls_t        w_cls;
  logic             w_wrap_cond;
  logic [3:0]       w_idle_cnt_nxt;
  logic             w_idle_nxt;
  logic             w_phase_nxt;
  logic             w_dir_nxt;
  logic [LED_W-1:0] w_pattern;
  logic [LED_W-1:0] w_led_nxt;

  wf_step_classify u_classify (
    .cnt_q     (r_cnt_q),
    .prev_q    (r_prev_q),
    .step_cls  (w_cls),
    .wrap_cond (w_wrap_cond)
  );

  always_comb begin
    w_idle_cnt_nxt = 4'd0;
    w_dir_nxt      = dir;
    w_pattern      = '0;

    if (w_cls == HOLD) begin
      w_idle_cnt_nxt = (r_idle_cnt == C_IDLE_MAX) ? r_idle_cnt : r_idle_cnt + 4'd1;
    end
    w_idle_nxt = (w_idle_cnt_nxt == C_IDLE_MAX);

    if (w_cls == STEP_UP) begin
      w_dir_nxt = 1'b1;
    end else if (w_cls == STEP_DN) begin
      w_dir_nxt = 1'b0;
    end

    case (mode)
      MODE_DOT: begin
        w_pattern[r_cnt_q] = 1'b1;
      end
      MODE_TRAIL: begin
        w_pattern[r_cnt_q] = 1'b1;
        if ((w_cls == STEP_UP) || (w_cls == STEP_DN)) begin
          w_pattern[r_prev_q] = 1'b1;
        end
      end
      MODE_BAR: begin
        for (int i = 0; i < LED_W; i++) begin
          w_pattern[i] = w_dir_nxt ? (i <= int'(r_cnt_q)) : (i >= int'(r_cnt_q));
        end
      end
      default: w_pattern = '0;
    endcase

    // Blank on the old phase so the first idle cycle still shows the pattern
    w_phase_nxt = w_idle_nxt & ~r_phase;
    w_led_nxt   = (w_idle_nxt && r_phase) ? '0 : w_pattern;
  end

  always_ff @(posedge clk_1hz or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_q    <= '0;
      r_prev_q   <= '0;
      r_idle_cnt <= 4'd0;
      r_phase    <= 1'b0;
      led        <= '0;
      dir        <= 1'b1;
      wrap       <= 1'b0;
      idle       <= 1'b0;
    end else begin
      r_cnt_q    <= count;
      r_prev_q   <= r_cnt_q;
      r_idle_cnt <= w_idle_cnt_nxt;
      r_phase    <= w_phase_nxt;
      led        <= w_led_nxt;
      dir        <= w_dir_nxt;
      wrap       <= w_wrap_cond;
      idle       <= w_idle_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_waterfall_led_driver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_waterfall_led_driver: directed vector bench for the LED driver   |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module tb_waterfall_led_driver;

  typedef struct {
    logic [2:0] cnt;
    logic [1:0] md;
    logic [7:0] led;
    logic       dir;
    logic       wrap;
    logic       idle;
  } vec_t;

  localparam int NVEC = 36;

  logic       clk_1hz;
  logic       rst_n;
  logic [2:0] count;
  logic [1:0] mode;
  logic [7:0] led;
  logic       dir;
  logic       wrap;
  logic       idle;

  int   checks;
  int   failures;
  vec_t vecs [0:NVEC-1];

  waterfall_led_driver #(.IDLE_CYC(4)) dut (
    .clk_1hz (clk_1hz),
    .rst_n   (rst_n),
    .count   (count),
    .mode    (mode),
    .led     (led),
    .dir     (dir),
    .wrap    (wrap),
    .idle    (idle)
  );

  initial clk_1hz = 1'b0;
  always #5 clk_1hz = ~clk_1hz;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_led, input logic e_dir,
                         input logic e_wrap, input logic e_idle);
    chk({tag, " led"},  led,          e_led);
    chk({tag, " dir"},  {7'd0, dir},  {7'd0, e_dir});
    chk({tag, " wrap"}, {7'd0, wrap}, {7'd0, e_wrap});
    chk({tag, " idle"}, {7'd0, idle}, {7'd0, e_idle});
  endtask

  task automatic tick(input logic [2:0] c, input logic [1:0] m);
    count = c;
    mode  = m;
    @(posedge clk_1hz);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // Each row: inputs applied before an edge, outputs expected just after it
    // (they reflect the count driven one row earlier).
    vecs[0]  = '{3'd0, 2'd0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{3'd0, 2'd0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd0, 2'd0, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'd6, 2'd0, 8'h01, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{3'd7, 2'd0, 8'h40, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{3'd0, 2'd0, 8'h80, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{3'd1, 2'd0, 8'h01, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{3'd3, 2'd0, 8'h02, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd2, 2'd1, 8'h08, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 2'd1, 8'h0C, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd0, 2'd1, 8'h06, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'd7, 2'd1, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'd4, 2'd1, 8'h81, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'd5, 2'd2, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'd4, 2'd2, 8'h3F, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{3'd4, 2'd2, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{3'd4, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{3'd3, 2'd0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{3'd3, 2'd0, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{3'd3, 2'd0, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{3'd3, 2'd0, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{3'd3, 2'd0, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{3'd3, 2'd0, 8'h08, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{3'd3, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[24] = '{3'd3, 2'd0, 8'h08, 1'b0, 1'b0, 1'b1};
    vecs[25] = '{3'd4, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[26] = '{3'd4, 2'd0, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[27] = '{3'd5, 2'd0, 8'h10, 1'b1, 1'b0, 1'b0};
    vecs[28] = '{3'd4, 2'd0, 8'h20, 1'b1, 1'b0, 1'b0};
    vecs[29] = '{3'd4, 2'd0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[30] = '{3'd0, 2'd0, 8'h10, 1'b0, 1'b0, 1'b0};
    vecs[31] = '{3'd0, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[32] = '{3'd0, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[33] = '{3'd0, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[34] = '{3'd0, 2'd0, 8'h01, 1'b0, 1'b0, 1'b0};
    vecs[35] = '{3'd0, 2'd0, 8'h01, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    count = 3'd0;
    mode  = 2'd0;
    repeat (2) @(posedge clk_1hz);
    #1;
    chk_all("reset", 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk_1hz);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      tick(vecs[i].cnt, vecs[i].md);
      chk_all($sformatf("vec%0d", i), vecs[i].led, vecs[i].dir, vecs[i].wrap, vecs[i].idle);
    end

    // Asynchronous reset while idle and lit with dir=0
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst_idle", 8'h00, 1'b1, 1'b0, 1'b0);
    @(negedge clk_1hz);
    rst_n = 1'b1;

    // 0 -> 7 wrap pulse, then reset in the middle of the pulse
    tick(3'd7, 2'd0);
    chk_all("post_rst_hold", 8'h01, 1'b1, 1'b0, 1'b0);
    tick(3'd7, 2'd0);
    chk_all("wrap_dn", 8'h80, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst_wrap", 8'h00, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
